// File: rtl/l2_mem_master.sv
// TileLink-UL initiator: line read/write commands out on A, source-tracked D responses back on rsp.
// Define L2_MEM_MASTER_FULLPUT_EN to issue PutFullData for writes with an all-ones mask.
module l2_mem_master #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int SOURCE_W = 2,
    parameter int NUM_SRC  = 4,
    parameter int TAG_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic [DATA_W/8-1:0]   cmd_mask,
    input  logic [TAG_W-1:0]      cmd_tag,
    output logic                  a_valid,
    input  logic                  a_ready,
    output logic [2:0]            a_opcode,
    output logic [2:0]            a_param,
    output logic [2:0]            a_size,
    output logic [SOURCE_W-1:0]   a_source,
    output logic [ADDR_W-1:0]     a_address,
    output logic [DATA_W/8-1:0]   a_mask,
    output logic [DATA_W-1:0]     a_data,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [2:0]            d_opcode,
    input  logic [2:0]            d_size,
    input  logic [2:0]            d_param,
    input  logic [SOURCE_W-1:0]   d_source,
    input  logic [DATA_W-1:0]     d_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err,
    output logic                  err_unexp,
    output logic                  busy
);
    localparam int MASK_W = DATA_W / 8;
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_PUT_FULL  = 3'd0;
    localparam logic [2:0] OP_PUT_PART  = 3'd1;
    localparam logic [2:0] D_ACK        = 3'd0;
    localparam logic [2:0] D_ACK_DATA   = 3'd1;

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the
    // sender holds valid and payload stable until then.

    logic [NUM_SRC-1:0] inuse;
    logic [NUM_SRC-1:0] ent_write;
    logic [TAG_W-1:0]   ent_tag [NUM_SRC];

    logic                have_free;
    logic [SOURCE_W-1:0] free_id;
    logic                hit;
    logic                hit_write;
    logic [TAG_W-1:0]    hit_tag;
    logic [2:0]          write_op;
    logic                cmd_fire;
    logic                d_fire;
    logic                unused_ok;

    assign unused_ok = ^{d_size, d_param};

    // Lowest free entry; scanning downward lets the lowest index win.
    always_comb begin
        have_free = 1'b0;
        free_id   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!inuse[i]) begin
                have_free = 1'b1;
                free_id   = SOURCE_W'(i);
            end
        end
    end

    // Sources at or beyond NUM_SRC never match and count as unexpected.
    always_comb begin
        hit       = 1'b0;
        hit_write = 1'b0;
        hit_tag   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (d_source == SOURCE_W'(i)) begin
                hit       = inuse[i];
                hit_write = ent_write[i];
                hit_tag   = ent_tag[i];
            end
        end
    end

    always_comb begin
`ifdef L2_MEM_MASTER_FULLPUT_EN
        write_op = (&cmd_mask) ? OP_PUT_FULL : OP_PUT_PART;
`else
        write_op = OP_PUT_PART;
`endif
    end

    assign cmd_ready = !rst && have_free && (!a_valid || a_ready);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign d_ready   = !rsp_valid || rsp_ready;
    assign d_fire    = d_valid && d_ready;
    assign a_param   = 3'd0;
    assign a_size    = 3'($clog2(MASK_W));
    assign busy      = (|inuse) || a_valid || rsp_valid;

    // Free and allocate never collide: the allocator picks from the pre-free vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inuse     <= '0;
            ent_write <= '0;
            for (int i = 0; i < NUM_SRC; i++) ent_tag[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (d_fire && hit && d_source == SOURCE_W'(i)) inuse[i] <= 1'b0;
                if (cmd_fire && free_id == SOURCE_W'(i)) begin
                    inuse[i]     <= 1'b1;
                    ent_write[i] <= cmd_write;
                    ent_tag[i]   <= cmd_tag;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_opcode  <= '0;
            a_source  <= '0;
            a_address <= '0;
            a_mask    <= '0;
            a_data    <= '0;
        end else if (cmd_fire) begin
            a_valid   <= 1'b1;
            a_opcode  <= cmd_write ? write_op : OP_GET;
            a_source  <= free_id;
            a_address <= cmd_addr;
            a_mask    <= cmd_write ? cmd_mask : {MASK_W{1'b1}};
            a_data    <= cmd_write ? cmd_data : '0;
        end else if (a_ready) begin
            a_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_unexp <= 1'b0;
        end else begin
            if (d_fire && hit) begin
                rsp_valid <= 1'b1;
                rsp_write <= hit_write;
                rsp_tag   <= hit_tag;
                rsp_data  <= hit_write ? '0 : d_data;
                rsp_err   <= hit_write ? (d_opcode != D_ACK) : (d_opcode != D_ACK_DATA);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (d_fire && !hit) err_unexp <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l2_mem_master.sv
// Directed bench for l2_mem_master; honours L2_MEM_MASTER_FULLPUT_EN for expected write opcodes.
module tb_l2_mem_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [63:0] cmd_data = '0;
    logic [7:0]  cmd_mask = '0;
    logic [3:0]  cmd_tag = '0;
    logic        a_valid, a_ready = 1'b1;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid = 1'b0, d_ready;
    logic [2:0]  d_opcode = '0, d_size = 3'd3, d_param = '0;
    logic [1:0]  d_source = '0;
    logic [63:0] d_data = '0;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_err, err_unexp, busy;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_data;

    int n_vec  = 0;
    int n_miss = 0;

`ifdef L2_MEM_MASTER_FULLPUT_EN
    localparam logic [2:0] EXP_FULL_OP = 3'd0;
`else
    localparam logic [2:0] EXP_FULL_OP = 3'd1;
`endif

    l2_mem_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_tag(cmd_tag),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_param(d_param), .d_source(d_source), .d_data(d_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .err_unexp(err_unexp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command, wait (bounded) for acceptance; returns 1ns after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] mask, input logic [3:0] tag);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_data = data; cmd_mask = mask; cmd_tag = tag;
        #1;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) check_eq("cmd_timeout", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic send_d(input logic [1:0] src, input logic [2:0] op, input logic [63:0] data);
        int n = 0;
        d_valid = 1'b1; d_source = src; d_opcode = op; d_data = data;
        #1;
        while (!d_ready && n < 20) begin
            tick();
            n++;
        end
        if (!d_ready) check_eq("d_timeout", d_ready, 1);
        tick();
        d_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        check_eq("rst_cmd_ready", cmd_ready, 0);
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_cmd_ready", cmd_ready, 1);
        check_eq("post_rst_rsp_valid", rsp_valid, 0);
        check_eq("post_rst_err_unexp", err_unexp, 0);
        check_eq("post_rst_payload", {a_opcode, a_address, a_mask, rsp_tag, rsp_data}, 0);

        // Single read
        send_cmd(1'b0, 32'h9000_0000, 64'hDEAD_BEEF, 8'h00, 4'd3);
        check_eq("rd_a_valid", a_valid, 1);
        check_eq("rd_a_opcode", a_opcode, 4);
        check_eq("rd_a_source", a_source, 0);
        check_eq("rd_a_address", a_address, 32'h9000_0000);
        check_eq("rd_a_mask", a_mask, 8'hFF);
        check_eq("rd_a_data", a_data, 0);
        check_eq("rd_a_size", a_size, 3);
        check_eq("rd_a_param", a_param, 0);
        check_eq("rd_busy", busy, 1);
        tick();
        check_eq("rd_a_drop", a_valid, 0);
        send_d(2'd0, 3'd1, 64'h1122_3344_5566_7788);
        check_eq("rd_rsp_valid", rsp_valid, 1);
        check_eq("rd_rsp_tag", rsp_tag, 3);
        check_eq("rd_rsp_data", rsp_data, 64'h1122_3344_5566_7788);
        check_eq("rd_rsp_err", rsp_err, 0);
        check_eq("rd_rsp_write", rsp_write, 0);
        tick();
        check_eq("rd_rsp_drop", rsp_valid, 0);
        check_eq("rd_idle", busy, 0);

        // Writes, full and partial mask
        send_cmd(1'b1, 32'h0000_1000, 64'hA5A5_0000_FFFF_1234, 8'hFF, 4'd5);
        check_eq("wrf_opcode", a_opcode, EXP_FULL_OP);
        check_eq("wrf_mask", a_mask, 8'hFF);
        check_eq("wrf_data", a_data, 64'hA5A5_0000_FFFF_1234);
        check_eq("wrf_source", a_source, 0);
        send_d(2'd0, 3'd0, 64'h7777);
        check_eq("wrf_rsp_write", rsp_write, 1);
        check_eq("wrf_rsp_tag", rsp_tag, 5);
        check_eq("wrf_rsp_data", rsp_data, 0);
        check_eq("wrf_rsp_err", rsp_err, 0);
        send_cmd(1'b1, 32'h0000_2000, 64'h0102_0304_0506_0708, 8'h0F, 4'd6);
        check_eq("wrp_opcode", a_opcode, 1);
        check_eq("wrp_mask", a_mask, 8'h0F);
        send_d(2'd0, 3'd0, 64'h0);
        check_eq("wrp_rsp_tag", rsp_tag, 6);
        check_eq("wrp_rsp_write", rsp_write, 1);
        tick();

        // Four outstanding reads, out-of-order completion, full table
        send_cmd(1'b0, 32'h100, 0, 0, 4'd8);
        check_eq("ooo_src0", a_source, 0);
        send_cmd(1'b0, 32'h108, 0, 0, 4'd9);
        check_eq("ooo_src1", a_source, 1);
        send_cmd(1'b0, 32'h110, 0, 0, 4'd10);
        check_eq("ooo_src2", a_source, 2);
        send_cmd(1'b0, 32'h118, 0, 0, 4'd11);
        check_eq("ooo_src3", a_source, 3);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h120; cmd_tag = 4'd12;
        #1;
        check_eq("full_cmd_ready", cmd_ready, 0);
        d_valid = 1'b1; d_source = 2'd2; d_opcode = 3'd1; d_data = 64'hAAAA;
        #1;
        check_eq("full_d_ready", d_ready, 1);
        check_eq("free_same_cycle", cmd_ready, 0);
        tick();
        check_eq("ooo_rsp_a", rsp_tag, 10);
        check_eq("ooo_data_a", rsp_data, 64'hAAAA);
        check_eq("reuse_cmd_ready", cmd_ready, 1);
        d_source = 2'd0; d_data = 64'hBBBB;
        tick();
        cmd_valid = 1'b0;
        check_eq("ooo_rsp_b", rsp_tag, 8);
        check_eq("reuse_a_valid", a_valid, 1);
        check_eq("reuse_a_source", a_source, 2);
        d_valid = 1'b0;
        send_d(2'd3, 3'd1, 64'hCCCC);
        check_eq("ooo_rsp_c", rsp_tag, 11);
        send_d(2'd1, 3'd1, 64'hDDDD);
        check_eq("ooo_rsp_d", rsp_tag, 9);
        check_eq("ooo_data_d", rsp_data, 64'hDDDD);
        send_d(2'd2, 3'd1, 64'hEEEE);
        check_eq("ooo_rsp_e", rsp_tag, 12);
        tick();
        check_eq("ooo_idle", busy, 0);

        // A-channel backpressure
        a_ready = 1'b0;
        send_cmd(1'b0, 32'h0000_4000, 0, 0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_a_valid", a_valid, 1);
            check_eq("bp_a_address", a_address, 32'h0000_4000);
            check_eq("bp_a_source", a_source, 0);
            check_eq("bp_cmd_ready", cmd_ready, 0);
            tick();
        end
        a_ready = 1'b1;
        #1;
        check_eq("bp_cmd_ready_rel", cmd_ready, 1);
        send_cmd(1'b0, 32'h0000_4008, 0, 0, 4'd2);
        check_eq("bp_a_source2", a_source, 1);
        tick();
        check_eq("bp_a_drop", a_valid, 0);

        // Response backpressure
        rsp_ready = 1'b0;
        send_d(2'd0, 3'd1, 64'h1111);
        check_eq("rbp_rsp_valid", rsp_valid, 1);
        d_valid = 1'b1; d_source = 2'd1; d_opcode = 3'd1; d_data = 64'h2222;
        for (int i = 0; i < 3; i++) begin
            check_eq("rbp_d_ready", d_ready, 0);
            check_eq("rbp_rsp_tag", rsp_tag, 1);
            check_eq("rbp_rsp_data", rsp_data, 64'h1111);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("rbp_d_ready_rel", d_ready, 1);
        tick();
        d_valid = 1'b0;
        check_eq("rbp_rsp2_valid", rsp_valid, 1);
        check_eq("rbp_rsp2_tag", rsp_tag, 2);
        check_eq("rbp_rsp2_data", rsp_data, 64'h2222);
        tick();
        check_eq("rbp_drop", rsp_valid, 0);

        // Unexpected D and opcode mismatch
        send_d(2'd1, 3'd1, 64'h5555);
        check_eq("unexp_flag", err_unexp, 1);
        check_eq("unexp_no_rsp", rsp_valid, 0);
        send_cmd(1'b0, 32'h0000_5000, 0, 0, 4'd7);
        send_d(2'd0, 3'd0, 64'h6666);
        check_eq("opc_rsp_err", rsp_err, 1);
        check_eq("opc_rsp_tag", rsp_tag, 7);
        check_eq("opc_rsp_write", rsp_write, 0);
        check_eq("unexp_sticky", err_unexp, 1);
        tick();

        // Reset mid-operation
        send_cmd(1'b0, 32'h0000_6000, 0, 0, 4'd13);
        send_cmd(1'b0, 32'h0000_6008, 0, 0, 4'd14);
        check_eq("mrst_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_a_valid", a_valid, 0);
        check_eq("mrst_cmd_ready", cmd_ready, 0);
        check_eq("mrst_err_clear", err_unexp, 0);
        tick();
        rst = 1'b0;
        tick();
        send_d(2'd1, 3'd1, 64'h9999);
        check_eq("mrst_stale_d", err_unexp, 1);
        check_eq("mrst_stale_no_rsp", rsp_valid, 0);
        send_cmd(1'b0, 32'h0000_7000, 0, 0, 4'd15);
        check_eq("mrst_realloc_src", a_source, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/l2_mem_master.md
# l2_mem_master

TileLink-UL initiator that turns line-granular read/write commands into A-channel requests toward the external memory interface. It receives matching D-channel responses and returns them on a command-response port. It sits between an L2 slice's miss/writeback logic and the memory-side A/D bus, so it is the requesting end of the bus the memory responder serves. Up to NUM_SRC requests can be outstanding, tracked by source ID, and responses may complete out of order.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 64, line/beat data width (single-beat transfers only)
- SOURCE_W, 2, A/D source field width
- NUM_SRC, 4, outstanding IDs, ≤ 2^SOURCE_W
- TAG_W, 4, opaque command tag returned with the response
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid / cmd_ready  in/out  1  command handshake
- cmd_write  in  1  1 = write line, 0 = read line
- cmd_addr  in  ADDR_W  line address, aligned to DATA_W/8
- cmd_data  in  DATA_W  write data
- cmd_mask  in  DATA_W/8  byte enables for writes
- cmd_tag  in  TAG_W  requester tag
- a_valid / a_ready  out/in  1  A-channel handshake
- a_opcode  out  3  4 = Get, 0 = PutFullData, 1 = PutPartialData
- a_param  out  3  always 0
- a_size  out  3  constant log2(DATA_W/8)
- a_source  out  SOURCE_W  allocated ID
- a_address / a_mask / a_data  out  ADDR_W / DATA_W/8 / DATA_W  request payload
- d_valid / d_ready  in/out  1  D-channel handshake
- d_opcode  in  3  1 = AccessAckData, 0 = AccessAck
- d_size / d_param  in  3 / 3  ignored
- d_source  in  SOURCE_W  ID being completed
- d_data  in  DATA_W  read data
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_write, rsp_tag, rsp_data  out  1, TAG_W, DATA_W  completed command
- rsp_err  out  1  D opcode did not match the request type
- err_unexp  out  1  sticky flag: a D beat arrived on an ID not in flight
- busy  out  1  at least one ID is in flight, or A/rsp registers are occupied

## Operation
- Tracking table holds NUM_SRC entries of {inuse, write, tag}.
- Free ID is the lowest-index entry with inuse = 0.
- cmd_ready = (a free ID exists) && (!a_valid || a_ready).
- Command accept (cmd_valid && cmd_ready):
  - Mark the chosen entry inuse and store write/tag.
  - Load the A registers: opcode Get when cmd_write = 0, otherwise per Configuration; a_mask = cmd_mask for writes and all-ones for reads; a_data = cmd_data for writes and 0 for reads.
- A registers hold stable while a_valid && !a_ready. a_valid drops after the handshake unless a new command loads in the same cycle.
- d_ready = !rsp_valid || rsp_ready, using a single response register.
- D accept on an entry with inuse = 1:
  - Clear inuse.
  - Load the response: rsp_write = entry.write, rsp_tag = entry.tag.
  - rsp_data = d_data for reads and 0 for writes.
  - rsp_err = 1 when (write && d_opcode ≠ 0) || (!write && d_opcode ≠ 1).
- D accept on an entry with inuse = 0: drop the beat, set err_unexp (cleared only by rst), and leave rsp unchanged.
- Same-cycle free and allocate: the allocator uses the pre-free inuse vector, so a freed ID becomes reusable the next cycle.
- Table full (all NUM_SRC entries inuse): cmd_ready = 0. D remains accepted.

## Timing
- Command accepted in cycle N → a_valid = 1 in N+1. Back-to-back accepts give one A beat per cycle when a_ready = 1.
- D accepted in cycle M → rsp_valid = 1 in M+1. The bridge sustains one response per cycle when rsp_ready = 1.
- Reset values: a_valid = 0, rsp_valid = 0, err_unexp = 0, busy = 0, all inuse = 0. All A/rsp payload outputs are 0. cmd_ready is 1 one cycle after rst deasserts, and is forced to 0 while rst is high.
- rst asserted mid-operation: all in-flight state is discarded immediately. A D beat arriving later for a pre-reset ID sets err_unexp.

## Configuration
- L2_MEM_MASTER_FULLPUT_EN defined: a write whose cmd_mask is all ones issues PutFullData (0); any other mask issues PutPartialData (1).
- Not defined: every write issues PutPartialData (1). Reads are unaffected in both builds.

## Test plan
- Read: cmd addr 0x90000000, tag 3, a_ready = 1. Expect A in the next cycle with opcode 4 and source 0. Drive D opcode 1, data 0x1122334455667788. Expect rsp_tag = 3, rsp_data = 0x1122334455667788, rsp_err = 0.
- Write, mask 0xFF and 0x0F: opcode 0 / 1 with the macro defined, 1 / 1 without it. An AccessAck gives rsp_write = 1 and rsp_data = 0.
- Four reads with D returned in source order 2, 0, 3, 1: the response tags follow the D order. A fifth command sees cmd_ready = 0 until the first D beat is accepted.
- Backpressure: a_ready held at 0 for 5 cycles keeps the A payload stable. rsp_ready held at 0 forces d_ready = 0, and no response is lost.
- Unexpected D on source 1 while idle sets err_unexp = 1 and produces no rsp_valid. A Get answered with d_opcode 0 gives rsp_err = 1.
- rst pulsed with 2 IDs in flight: busy = 0 and a_valid = 0 at once. The next command is allocated source 0.
